// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: fixed scanout read slot every 4 pixel clocks, remaining
// slots shared by the game-logic writer and a full-screen clear engine.
module vga_fb_arbiter #(
    parameter int unsigned FB_W     = 160,
    parameter int unsigned FB_H     = 120,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [9:0]        i_hcount,
    input  logic [9:0]        i_vcount,
    input  logic              i_video_on,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [2:0]        i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_clear_req,
    input  logic [2:0]        i_clear_color,
    output logic              o_clear_busy,
    output logic              o_vblank_pulse,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [2:0]        o_mem_wdata,
    input  logic [2:0]        i_mem_rdata,
    output logic [2:0]        o_rgb
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [2:0]        r_clr_color;
    logic              r_clear_busy;
    logic              r_wr_ack;
    logic              r_vblank;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [2:0]        r_mem_wdata;
    logic [2:0]        r_pix;
    logic [2:0]        r_von_dly;
    logic [1:0]        r_rd_dly;

    logic              w_rd_slot;
    logic              w_wr_grant;
    logic              w_clr_grant;
    logic              w_clr_start;
    logic              w_vblank;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_rd_slot   = i_video_on && (i_hcount[1:0] == 2'b00);
    assign w_rd_addr   = ADDR_W'(ADDR_W'(i_vcount >> 2) * ADDR_W'(FB_W) + ADDR_W'(i_hcount >> 2));
    // !r_wr_ack keeps a held request from being granted a second time.
    assign w_wr_grant  = !w_rd_slot && (r_state == S_IDLE) && i_wr_req && !r_wr_ack;
    assign w_clr_grant = !w_rd_slot && (r_state == S_CLEAR);
    assign w_clr_start = (r_state == S_IDLE) && i_clear_req;
    assign w_vblank    = (i_vcount == 10'(V_ACTIVE)) && (i_hcount == 10'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_clr_cnt    <= '0;
            r_clr_color  <= '0;
            r_clear_busy <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_vblank     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_pix        <= '0;
            r_von_dly    <= '0;
            r_rd_dly     <= '0;
        end else begin
            r_wr_ack  <= w_wr_grant;
            r_vblank  <= w_vblank;
            r_von_dly <= {r_von_dly[1:0], i_video_on};
            r_rd_dly  <= {r_rd_dly[0], w_rd_slot};
            r_mem_we  <= w_wr_grant || w_clr_grant;

            // Read data arrives two clocks after the read slot.
            if (r_rd_dly[1]) begin
                r_pix <= i_mem_rdata;
            end

            if (w_rd_slot) begin
                r_mem_addr <= w_rd_addr;
            end else if (w_wr_grant) begin
                r_mem_addr  <= i_wr_addr;
                r_mem_wdata <= i_wr_data;
            end else if (w_clr_grant) begin
                r_mem_addr  <= r_clr_cnt;
                r_mem_wdata <= r_clr_color;
            end

            if (w_clr_start) begin
                r_state      <= S_CLEAR;
                r_clr_cnt    <= '0;
                r_clr_color  <= i_clear_color;
                r_clear_busy <= 1'b1;
            end else if (w_clr_grant) begin
                if (r_clr_cnt == CLR_LAST) begin
                    r_state      <= S_IDLE;
                    r_clr_cnt    <= '0;
                    r_clear_busy <= 1'b0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    assign o_wr_ack       = r_wr_ack;
    assign o_clear_busy   = r_clear_busy;
    assign o_vblank_pulse = r_vblank;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_we       = r_mem_we;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_rgb          = r_von_dly[2] ? r_pix : 3'b000;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: behavioural RAM, write scoreboard with a monitor, and
// directed scanout / writer / clear / reset / vblank scenarios.
module tb_vga_fb_arbiter;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned FB_SIZE  = FB_W * FB_H;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              video_on;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic              wr_ack;
    logic              clear_req;
    logic [2:0]        clear_color;
    logic              clear_busy;
    logic              vblank_pulse;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [2:0]        mem_wdata;
    logic [2:0]        mem_rdata;
    logic [2:0]        rgb;

    logic [2:0]        ram [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr;
    logic [2:0]        pl_data;

    int  n_checks = 0;
    int  n_fails  = 0;
    int  cyc      = 0;
    wr_t sb_q[$];
    logic mon_en = 1'b0;

    int   idx, bad_we, bad_ack, bad_busy, vb_cnt;
    logic prev_ack, prev_rd, exp_we, exp_ack, exp_busy;
    wr_t  e;

    vga_fb_arbiter #(
        .FB_W    (FB_W),
        .FB_H    (FB_H),
        .ADDR_W  (ADDR_W),
        .V_ACTIVE(V_ACTIVE)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_hcount      (hcount),
        .i_vcount      (vcount),
        .i_video_on    (video_on),
        .i_wr_req      (wr_req),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_ack      (wr_ack),
        .i_clear_req   (clear_req),
        .i_clear_color (clear_color),
        .o_clear_busy  (clear_busy),
        .o_vblank_pulse(vblank_pulse),
        .o_mem_addr    (mem_addr),
        .o_mem_we      (mem_we),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_rgb         (rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port synchronous RAM, read-first, one-clock read latency.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_loop();
        wr_t m;
        forever begin
            @(negedge clk);
            if (mon_en && mem_we) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL sb_unexpected_write: got addr %0d data %0d, want no write (cycle %0d)",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    m = sb_q.pop_front();
                    check("sb_addr", 32'(mem_addr), 32'(m.addr));
                    check("sb_data", 32'(mem_wdata), 32'(m.data));
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hcount    = 10'd1;
        vcount    = 10'd481;
        video_on  = 1'b0;
        wr_req    = 1'b0;
        clear_req = 1'b0;
    endtask

    // Start a clear, let n writes issue, then reset while the counter equals n.
    task automatic clear_then_reset(input int n, input logic [2:0] color);
        wr_t c;
        idle_inputs();
        clear_req   = 1'b1;
        clear_color = color;
        for (int i = 0; i < n; i++) begin
            c.addr = ADDR_W'(i);
            c.data = color;
            sb_q.push_back(c);
        end
        tick();
        clear_req   = 1'b0;
        clear_color = ~color;
        for (int j = 1; j <= n + 1; j++) begin
            if (j == n + 1) reset = 1'b1;
            @(negedge clk);
            if (j == n + 1) check("rst_busy_before", 32'(clear_busy), 32'd1);
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy_after", 32'(clear_busy), 32'd0);
        check("rst_we_after", 32'(mem_we), 32'd0);
        check("rst_ack_after", 32'(wr_ack), 32'd0);
        tick();
        @(negedge clk);
        check("rst_we_idle", 32'(mem_we), 32'd0);
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor_loop();
        join_none

        // Reset with random inputs.
        reset = 1'b1;
        repeat (2) begin
            hcount      = 10'($urandom_range(0, 799));
            vcount      = 10'($urandom_range(0, 524));
            video_on    = 1'($urandom);
            wr_req      = 1'($urandom);
            wr_addr     = ADDR_W'($urandom);
            wr_data     = 3'($urandom);
            clear_req   = 1'($urandom);
            clear_color = 3'($urandom);
            tick();
        end
        @(negedge clk);
        check("reset_wr_ack", 32'(wr_ack), 32'd0);
        check("reset_clear_busy", 32'(clear_busy), 32'd0);
        check("reset_vblank", 32'(vblank_pulse), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_we", 32'(mem_we), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset_rgb", 32'(rgb), 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_mem_we", 32'(mem_we), 32'd0);
            check("idle_rgb", 32'(rgb), 32'd0);
            tick();
        end

        // Scanout of preloaded pixel (4,4) -> address 161.
        pl_en   = 1'b1;
        pl_addr = ADDR_W'(161);
        pl_data = 3'b101;
        tick();
        pl_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hcount   = 10'(4 + k);
            vcount   = 10'd4;
            video_on = (k < 4);
            @(negedge clk);
            if (k == 1) begin
                check("scan_mem_addr", 32'(mem_addr), 32'd161);
                check("scan_mem_we", 32'(mem_we), 32'd0);
            end
            check("scan_rgb", 32'(rgb), (k >= 3 && k <= 6) ? 32'd5 : 32'd0);
            tick();
        end

        // Write request arriving on a read slot waits one clock.
        e.addr = ADDR_W'(500);
        e.data = 3'b011;
        sb_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            hcount   = 10'(8 + k);
            vcount   = 10'd4;
            video_on = 1'b1;
            wr_req   = (k < 3);
            wr_addr  = ADDR_W'(500);
            wr_data  = 3'b011;
            @(negedge clk);
            if (k == 1) begin
                check("rdslot_mem_addr", 32'(mem_addr), 32'd162);
                check("rdslot_mem_we", 32'(mem_we), 32'd0);
                check("rdslot_ack", 32'(wr_ack), 32'd0);
            end
            if (k == 2) begin
                check("wr_mem_we", 32'(mem_we), 32'd1);
                check("wr_mem_addr", 32'(mem_addr), 32'd500);
                check("wr_mem_wdata", 32'(mem_wdata), 32'd3);
                check("wr_ack", 32'(wr_ack), 32'd1);
            end
            if (k == 3) check("wr_ack_drop", 32'(wr_ack), 32'd0);
            tick();
        end
        idle_inputs();

        // Writer holding requests through active video.
        for (int i = 0; i < 8; i++) begin
            e.addr = ADDR_W'(600 + i);
            e.data = 3'(i + 3);
            sb_q.push_back(e);
        end
        idx      = 0;
        prev_ack = 1'b0;
        prev_rd  = 1'b0;
        for (int k = 0; k < 200 && idx < 8; k++) begin
            hcount   = 10'(k);
            vcount   = 10'd8;
            video_on = (k < 40);
            wr_req   = 1'b1;
            wr_addr  = ADDR_W'(600 + idx);
            wr_data  = 3'(idx + 3);
            @(negedge clk);
            check("ack_back_to_back", 32'(wr_ack && prev_ack), 32'd0);
            check("ack_after_read", 32'(wr_ack && prev_rd), 32'd0);
            prev_ack = wr_ack;
            prev_rd  = video_on && (hcount[1:0] == 2'b00);
            if (wr_ack) idx++;
            tick();
        end
        idle_inputs();
        check("writer_done", 32'(idx), 32'd8);
        tick();
        check("ram_first", 32'(ram[600]), 32'd3);
        check("ram_last", 32'(ram[607]), 32'd2);

        // vblank pulse, then full clear while a writer waits.
        hcount = 10'd0;
        vcount = 10'(V_ACTIVE);
        @(negedge clk);
        check("vb_before", 32'(vblank_pulse), 32'd0);
        tick();
        hcount      = 10'd1;
        vcount      = 10'd481;
        clear_req   = 1'b1;
        clear_color = 3'b010;
        @(negedge clk);
        check("vb_pulse", 32'(vblank_pulse), 32'd1);
        for (int i = 0; i < int'(FB_SIZE); i++) begin
            e.addr = ADDR_W'(i);
            e.data = 3'b010;
            sb_q.push_back(e);
        end
        e.addr = ADDR_W'(700);
        e.data = 3'b111;
        sb_q.push_back(e);
        tick();
        clear_req   = 1'b0;
        clear_color = 3'b101;
        wr_req      = 1'b1;
        wr_addr     = ADDR_W'(700);
        wr_data     = 3'b111;
        bad_we   = 0;
        bad_ack  = 0;
        bad_busy = 0;
        for (int j = 1; j <= int'(FB_SIZE) + 3; j++) begin
            if (j == int'(FB_SIZE) + 3) wr_req = 1'b0;
            @(negedge clk);
            exp_we   = (j >= 2) && (j <= int'(FB_SIZE) + 2);
            exp_busy = (j <= int'(FB_SIZE));
            exp_ack  = (j == int'(FB_SIZE) + 2);
            if (j <= 2 || j >= int'(FB_SIZE)) begin
                check("clr_we", 32'(mem_we), 32'(exp_we));
                check("clr_busy", 32'(clear_busy), 32'(exp_busy));
                check("clr_ack", 32'(wr_ack), 32'(exp_ack));
            end else begin
                if (mem_we !== exp_we) bad_we++;
                if (clear_busy !== exp_busy) bad_busy++;
                if (wr_ack !== exp_ack) bad_ack++;
            end
            if (j == int'(FB_SIZE) + 1) check("clr_last_addr", 32'(mem_addr), FB_SIZE - 1);
            tick();
        end
        check("clr_run_we", 32'(bad_we), 32'd0);
        check("clr_run_busy", 32'(bad_busy), 32'd0);
        check("clr_run_ack", 32'(bad_ack), 32'd0);
        check("ram_cleared", 32'(ram[161]), 32'd2);

        // Reset mid-clear, then a fresh clear restarts at address 0.
        clear_then_reset(1000, 3'b110);
        clear_then_reset(10, 3'b001);

        // Exactly one vblank pulse.
        vb_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            hcount = 10'(k);
            vcount = 10'(V_ACTIVE);
            @(negedge clk);
            if (k == 1) check("vb_pulse2", 32'(vblank_pulse), 32'd1);
            if (vblank_pulse) vb_cnt++;
            tick();
        end
        idle_inputs();
        check("vb_count", 32'(vb_cnt), 32'd1);

        repeat (2) tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
